// File: rtl/uart_parity_pkg.sv
// uart_parity_pkg: mode and state encodings plus the parity rule used by the RX engine and future TX generator.
package uart_parity_pkg;
    localparam logic [2:0] MODE_NONE  = 3'b000;
    localparam logic [2:0] MODE_EVEN  = 3'b001;
    localparam logic [2:0] MODE_ODD   = 3'b010;
    localparam logic [2:0] MODE_MARK  = 3'b011;
    localparam logic [2:0] MODE_SPACE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_PAR   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic expected_parity(input logic [2:0] mode, input logic acc);
        return (mode == MODE_EVEN) ? acc : (mode == MODE_ODD) ? ~acc : (mode == MODE_MARK);
    endfunction

    // Reserved encodings behave as NONE, so fold them once when the mode is latched.
    function automatic logic [2:0] norm_mode(input logic [2:0] mode);
        return (mode > MODE_SPACE) ? MODE_NONE : mode;
    endfunction
endpackage

// File: rtl/parity_expect.sv
// parity_expect: parity bit required by a parity mode given the XOR of the data bits.
module parity_expect
    import uart_parity_pkg::*;
(
    input  logic [2:0] mode,
    input  logic       acc,
    output logic       expected
);
    always_comb expected = expected_parity(mode, acc);
endmodule

// File: rtl/uart_parity_engine.sv
// uart_parity_engine: serial LSB-first word assembler with runtime-selectable parity check,
// valid/ready result handshake, saturating error counter and sticky error flag.
module uart_parity_engine
    import uart_parity_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [2:0]           i_mode,
    input  logic                 i_bit_valid,
    input  logic                 i_bit,
    input  logic                 i_abort,
    input  logic                 i_result_ready,
    input  logic                 i_clear,
    output logic                 o_busy,
    output logic                 o_result_valid,
    output logic [WORD_SIZE-1:0] o_data,
    output logic                 o_expected_parity,
    output logic                 o_parity_error,
    output logic                 o_overrun,
    output logic [CNT_WIDTH-1:0] o_err_count,
    output logic                 o_sticky_error
);
    localparam int IW = $clog2(WORD_SIZE + 1);

    state_e               st;
    logic [2:0]           mode_q;
    logic [WORD_SIZE-1:0] sh;
    logic                 acc;
    logic [IW-1:0]        idx;
    logic                 exp_par;
    logic                 start;
    logic                 handshake;

    parity_expect u_parity_expect (
        .mode     (mode_q),
        .acc      (acc),
        .expected (exp_par)
    );

    // A strobe in DONE alongside ready is the first bit of the next frame, not an overrun.
    always_comb start = i_bit_valid && !i_abort &&
                        (st == ST_IDLE || (st == ST_DONE && i_result_ready));
    always_comb handshake = o_result_valid && i_result_ready && !i_abort;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st                <= ST_IDLE;
            mode_q            <= MODE_NONE;
            sh                <= '0;
            acc               <= 1'b0;
            idx               <= '0;
            o_busy            <= 1'b0;
            o_result_valid    <= 1'b0;
            o_data            <= '0;
            o_expected_parity <= 1'b0;
            o_parity_error    <= 1'b0;
            o_overrun         <= 1'b0;
            o_err_count       <= '0;
            o_sticky_error    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (i_clear) begin
                o_err_count    <= '0;
                o_sticky_error <= 1'b0;
            end else if (handshake && o_parity_error) begin
                o_err_count    <= (&o_err_count) ? o_err_count : o_err_count + 1'b1;
                o_sticky_error <= 1'b1;
            end
            if (i_abort) begin
                st                <= ST_IDLE;
                o_busy            <= 1'b0;
                o_result_valid    <= 1'b0;
                o_data            <= '0;
                o_expected_parity <= 1'b0;
                o_parity_error    <= 1'b0;
            end else if (start) begin
                st                <= ST_ACCUM;
                mode_q            <= norm_mode(i_mode);
                sh                <= {i_bit, {(WORD_SIZE-1){1'b0}}};
                acc               <= i_bit;
                idx               <= IW'(1);
                o_busy            <= 1'b1;
                o_result_valid    <= 1'b0;
                o_data            <= '0;
                o_expected_parity <= 1'b0;
                o_parity_error    <= 1'b0;
            end else begin
                case (st)
                    ST_ACCUM: if (i_bit_valid) begin
                        sh  <= {i_bit, sh[WORD_SIZE-1:1]};
                        acc <= acc ^ i_bit;
                        idx <= idx + 1'b1;
                        if (idx == IW'(WORD_SIZE - 1)) begin
                            if (mode_q == MODE_NONE) begin
                                st             <= ST_DONE;
                                o_busy         <= 1'b0;
                                o_result_valid <= 1'b1;
                                o_data         <= {i_bit, sh[WORD_SIZE-1:1]};
                            end else begin
                                st <= ST_PAR;
                            end
                        end
                    end
                    ST_PAR: if (i_bit_valid) begin
                        st                <= ST_DONE;
                        o_busy            <= 1'b0;
                        o_result_valid    <= 1'b1;
                        o_data            <= sh;
                        o_expected_parity <= exp_par;
                        o_parity_error    <= i_bit != exp_par;
                    end
                    ST_DONE: if (i_result_ready) begin
                        st                <= ST_IDLE;
                        o_result_valid    <= 1'b0;
                        o_data            <= '0;
                        o_expected_parity <= 1'b0;
                        o_parity_error    <= 1'b0;
                    end else if (i_bit_valid) begin
                        o_overrun <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_parity_engine.sv
// tb_uart_parity_engine: directed frames with a scoreboard of expected results checked by immediate assertions.
module tb_uart_parity_engine;
    localparam logic [2:0] M_NONE = 3'b000, M_EVEN = 3'b001, M_ODD = 3'b010, M_MARK = 3'b011, M_SPACE = 3'b100;

    typedef struct {
        logic [7:0] data;
        logic       exp;
        logic       perr;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = M_NONE;
    logic       bit_valid = 1'b0;
    logic       bit_v = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b0;
    logic       clear = 1'b0;
    logic       busy, result_valid, expected_parity, parity_error, overrun, sticky_error;
    logic [7:0] data, err_count;

    int   tests = 0;
    int   fails = 0;
    res_t sb[$];

    uart_parity_engine #(.WORD_SIZE(8), .CNT_WIDTH(8)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_mode            (mode),
        .i_bit_valid       (bit_valid),
        .i_bit             (bit_v),
        .i_abort           (abort),
        .i_result_ready    (ready),
        .i_clear           (clear),
        .o_busy            (busy),
        .o_result_valid    (result_valid),
        .o_data            (data),
        .o_expected_parity (expected_parity),
        .o_parity_error    (parity_error),
        .o_overrun         (overrun),
        .o_err_count       (err_count),
        .o_sticky_error    (sticky_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_v     = b;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    function automatic res_t model(input logic [7:0] d, input logic [2:0] m, input logic pb);
        res_t r;
        logic e;
        e = (m == M_EVEN) ? ^d : (m == M_ODD) ? ~^d : (m == M_MARK);
        r.data = d;
        r.exp  = (m >= M_EVEN && m <= M_SPACE) ? e : 1'b0;
        r.perr = (m >= M_EVEN && m <= M_SPACE) ? (pb != e) : 1'b0;
        return r;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [2:0] m, input logic pb);
        mode = m;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (m >= M_EVEN && m <= M_SPACE) send_bit(pb);
        sb.push_back(model(d, m, pb));
    endtask

    task automatic expect_result(input string tag);
        int   n;
        res_t r;
        n = 0;
        while (!result_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, n, 0);
        chk({tag, ".valid"}, result_valid, 1);
        chk({tag, ".sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk({tag, ".data"}, data, r.data);
            chk({tag, ".exp"}, expected_parity, r.exp);
            chk({tag, ".perr"}, parity_error, r.perr);
        end
    endtask

    task automatic accept();
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".valid"}, result_valid, 0);
        chk({tag, ".data"}, data, 0);
        chk({tag, ".exp"}, expected_parity, 0);
        chk({tag, ".perr"}, parity_error, 0);
        chk({tag, ".overrun"}, overrun, 0);
        chk({tag, ".count"}, err_count, 0);
        chk({tag, ".sticky"}, sticky_error, 0);
    endtask

    initial begin
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_frame(8'hA5, M_EVEN, 1'b0);
        expect_result("even_a5");
        accept();
        chk("even_a5.count", err_count, 0);
        chk("even_a5.idle_valid", result_valid, 0);

        send_frame(8'hA5, M_ODD, 1'b0);
        expect_result("odd_a5");
        accept();
        chk("odd_a5.count", err_count, 1);
        chk("odd_a5.sticky", sticky_error, 1);
        for (int k = 0; k < 255; k++) begin
            send_frame(8'hA5, M_ODD, 1'b0);
            expect_result("odd_loop");
            accept();
        end
        chk("saturate.count", err_count, 255);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear.count", err_count, 0);
        chk("clear.sticky", sticky_error, 0);

        send_frame(8'hFF, M_NONE, 1'b0);
        expect_result("none_ff");
        accept();
        send_frame(8'h3C, M_NONE, 1'b0);
        expect_result("none_next");
        accept();
        send_frame(8'h96, 3'b111, 1'b0);
        expect_result("mode7_as_none");
        accept();

        send_frame(8'h12, M_MARK, 1'b0);
        expect_result("mark");
        accept();
        send_frame(8'h12, M_SPACE, 1'b0);
        expect_result("space");
        accept();
        mode = M_EVEN;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) mode = M_ODD;
            send_bit(i[0] ? 1'b1 : 1'b0);
        end
        send_bit(1'b0);
        sb.push_back(model(8'hAA, M_EVEN, 1'b0));
        expect_result("mode_latched");
        accept();

        send_frame(8'hC3, M_EVEN, 1'b0);
        expect_result("overrun_frame");
        send_bit(1'b1);
        chk("overrun.pulse", overrun, 1);
        chk("overrun.data", data, 8'hC3);
        chk("overrun.valid", result_valid, 1);
        @(negedge clk);
        chk("overrun.one_cycle", overrun, 0);
        mode      = M_EVEN;
        ready     = 1'b1;
        bit_valid = 1'b1;
        bit_v     = 1'b1;
        @(negedge clk);
        ready     = 1'b0;
        bit_valid = 1'b0;
        chk("chain.busy", busy, 1);
        chk("chain.valid", result_valid, 0);
        for (int i = 1; i < 8; i++) send_bit(i == 7);
        send_bit(1'b0);
        sb.push_back(model(8'h81, M_EVEN, 1'b0));
        expect_result("chain_frame");
        accept();

        mode = M_ODD;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort.busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("abort.no_result", result_valid, 0);
        chk("abort.count", err_count, 1);
        send_frame(8'h01, M_EVEN, 1'b1);
        expect_result("after_abort");
        accept();

        mode = M_EVEN;
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        chk("par.busy", busy, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_frame(8'hA5, M_ODD, 1'b0);
        expect_result("err1");
        accept();
        chk("err1.count", err_count, 1);
        send_frame(8'hA5, M_ODD, 1'b0);
        expect_result("err2");
        clear = 1'b1;
        accept();
        clear = 1'b0;
        chk("clear_wins.count", err_count, 0);
        chk("clear_wins.sticky", sticky_error, 0);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_parity_engine.md
Name: uart_parity_engine

Overview:
Serial parity accumulator and checker for the UART receive path. It takes data bits one at a time, LSB first, as the RX deserializer samples them, and then takes the parity bit. It assembles the word and checks parity in one of five runtime-selectable modes. The result is presented through a valid/ready handshake, and the block keeps a saturating error counter and a sticky error flag for status registers. It sits between the RX bit sampler and the RX FIFO/status logic.

Parameters:
WORD_SIZE, 8, data bits per frame; legal range 5..9.
CNT_WIDTH, 8, width of the saturating parity-error counter.

Ports:
i_clk  in  1  system clock; all state changes on its rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_mode  in  3  parity mode: 000 NONE, 001 EVEN, 010 ODD, 011 MARK, 100 SPACE; 101..111 treated as NONE.
i_bit_valid  in  1  one-cycle strobe; i_bit is a sampled serial bit.
i_bit  in  1  serial bit value.
i_abort  in  1  drop the frame in progress (framing error or break from the sampler).
i_result_ready  in  1  consumer accepts the result.
i_clear  in  1  clears o_err_count and o_sticky_error.
o_busy  out  1  a frame is being accumulated (state ACCUM or PAR).
o_result_valid  out  1  o_data, o_parity_error and o_expected_parity are valid.
o_data  out  WORD_SIZE  assembled word; first bit received is placed in bit 0.
o_expected_parity  out  1  parity bit required by the latched mode.
o_parity_error  out  1  received parity bit differs from expected; always 0 in NONE mode.
o_overrun  out  1  one-cycle pulse: a bit arrived while in DONE and was discarded.
o_err_count  out  CNT_WIDTH  count of erroneous results consumed; saturates at all-ones.
o_sticky_error  out  1  set by any consumed erroneous result; held until i_clear.

Behaviour:
- Reset (async, i_rst=1): state IDLE; every output is 0; internal accumulator, bit index and latched mode are all 0.
- States: IDLE, ACCUM, PAR, DONE. Encoding is binary, 2 bits.
- IDLE
  - On i_bit_valid: latch i_mode, place i_bit into shift bit WORD_SIZE-1, set acc=i_bit, set idx=1, go to ACCUM.
  - i_mode is sampled only at this point; later changes have no effect on the current frame.
- ACCUM
  - On each i_bit_valid: shift right with the new bit entering at MSB, acc ^= i_bit, idx++.
  - On the WORD_SIZE-th data bit: go to PAR if the latched mode is not NONE; otherwise go to DONE.
  - Result after WORD_SIZE shifts: first-received bit is at o_data[0].
- PAR
  - On i_bit_valid: compute expected = EVEN: acc; ODD: ~acc; MARK: 1; SPACE: 0.
  - Set error = (i_bit != expected) and go to DONE.
- DONE
  - o_result_valid=1; o_data, o_expected_parity and o_parity_error are registered and stable.
  - Hold until i_result_ready=1, then return to IDLE on the next edge.
- Latency: o_result_valid rises on the edge that accepts the last bit, i.e. in the cycle after the parity strobe (or after the last data strobe in NONE mode).
- Outputs outside DONE:
  - o_data, o_expected_parity and o_parity_error are 0 outside DONE.
  - In NONE mode, o_expected_parity=0 and o_parity_error=0.
- Bit strobe in DONE:
  - A strobe with i_result_ready=0: the bit is discarded and o_overrun pulses for one cycle.
  - A strobe in the same cycle as i_result_ready=1: the bit is not discarded; it starts a new frame (DONE→ACCUM directly, same actions as in IDLE).
- i_abort: in any state, go to IDLE on the next edge.
  - No result is produced and the counter is not changed.
  - Abort takes priority over i_bit_valid and over i_result_ready.
- Error counter
  - Increments by 1 on the handshake cycle (o_result_valid & i_result_ready & o_parity_error).
  - Saturates at 2^CNT_WIDTH-1.
  - o_sticky_error is set on the same condition.
- Simultaneous i_clear and a counted handshake: i_clear wins; counter=0 and sticky=0 for that event.
- No bit strobes in ACCUM/PAR: the state is held indefinitely, with no timeout (timeouts belong to the sampler).

Decomposition:
- Package uart_parity_pkg holds:
  - mode constants: MODE_NONE, MODE_EVEN, MODE_ODD, MODE_MARK, MODE_SPACE;
  - state encoding: ST_IDLE, ST_ACCUM, ST_PAR, ST_DONE;
  - a function returning the expected parity from mode and acc.
- One combinational sub-module, parity_expect (inputs mode, acc; output expected), shared with the future TX parity generator.
- The FSM, shift register and counter stay in the top level.

Test Plan:
1. EVEN mode, bits 1,0,1,0,0,1,0,1 (0xA5, LSB first), parity bit 0 → one cycle after the parity strobe: o_result_valid=1, o_data=0xA5, o_expected_parity=0, o_parity_error=0; o_err_count stays 0.
2. ODD mode, same 0xA5 frame, parity bit 0 → o_expected_parity=1, o_parity_error=1. With i_result_ready=1: o_err_count=1 and o_sticky_error=1 the next cycle. Repeat 256 frames with CNT_WIDTH=8 → count holds at 255.
3. NONE mode, 8 data bits 0xFF → o_result_valid one cycle after the 8th strobe, o_data=0xFF, o_parity_error=0. The next strobe starts a new frame (it is not taken as a parity bit).
4. MARK mode with parity bit 0 → o_parity_error=1. SPACE mode with parity bit 0 → o_parity_error=0. Change i_mode mid-frame (EVEN→ODD after bit 3) → checking still uses EVEN.
5. Hold i_result_ready=0 in DONE and strobe a bit → o_overrun pulses for 1 cycle; o_data unchanged. Then assert i_result_ready together with a strobe → new frame starts; o_busy=1 the next cycle.
6. Assert i_abort after 4 bits → IDLE, o_busy=0, no result, counter unchanged. Assert i_rst mid-PAR → all outputs 0 immediately (async). Assert i_clear in the same cycle as an erroneous handshake → o_err_count=0, o_sticky_error=0.
